multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Moore-style control FSM that sequences the shared-memory multicycle MIPS datapath (one memory port for instructions and data, one ALU reused for PC increment, branch target and execute). It decodes the latched instruction's opcode/funct and steps each instruction through fetch, decode, execute, memory and writeback cycles. It stalls on a memory-ready handshake and counts retired instructions. It supports the same instruction subset as the single-cycle decoder: sll, srl, jr, other R-type, addi, addiu, lw, sw, beq and j.

## Interface
Parameters:
- CNT_W, 32: width of the retired-instruction counter.
- HALT_ON_ILLEGAL, 0: 1 = park in HALT on an unsupported opcode; 0 = skip the instruction and continue.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high.
- opcode  in  6  instruction register [31:26].
- funct  in  6  instruction register [5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current read/write this cycle.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- memread  out  1  memory read strobe.
- memwrite  out  1  memory write strobe.
- irwrite  out  1  load the instruction register.
- regdest  out  1  destination register: 1 = rd, 0 = rt.
- memtoreg  out  1  writeback data: 1 = memory data register, 0 = ALUOut.
- regwrite  out  1  register file write.
- alusrcA  out  2  ALU A input: 0 = PC, 1 = register A, 2 = shamt.
- alusrcB  out  2  ALU B input: 0 = register B, 1 = constant 4, 2 = sign-extended immediate, 3 = sign-extended immediate << 2.
- aluop  out  2  0 = add, 1 = sub, 2 = decode from funct.
- pcsrc  out  2  next PC: 0 = ALU result, 1 = ALUOut, 2 = jump target, 3 = register A.
- pcen  out  1  PC write enable.
- instr_done  out  1  one-cycle pulse in the final cycle of each retired instruction.
- retired  out  CNT_W  count of retired instructions.
- illegal  out  1  sticky flag: an unsupported opcode was decoded.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REX, RWB, IEX, IWB, BEQ, JMP, JR, HALT.
- Every output not listed for a state is 0.
- FETCH:
  - Asserts memread=1, iord=0, alusrcA=0, alusrcB=1, aluop=0, pcsrc=0.
  - irwrite and pcen equal mem_ready.
  - Moves to DECODE when mem_ready=1; otherwise holds.
- DECODE:
  - Asserts alusrcA=0, alusrcB=3, aluop=0 (branch target into ALUOut).
  - Next state by opcode:
    - 0x23 or 0x2B: MEMADR.
    - 0x00 with funct 0x08: JR.
    - 0x00 with any other funct: REX.
    - 0x08 or 0x09: IEX.
    - 0x04: BEQ.
    - 0x02: JMP.
    - Any other opcode: sets illegal; goes to HALT if HALT_ON_ILLEGAL=1, else FETCH. No instr_done, no count.
- MEMADR: alusrcA=1, alusrcB=2, aluop=0. Next state MEMRD for lw, MEMWR for sw.
- MEMRD: memread=1, iord=1. Moves to MEMWB when mem_ready=1; otherwise holds.
- MEMWB: regwrite=1, regdest=0, memtoreg=1. Goes to FETCH.
- MEMWR:
  - Asserts memwrite=1, iord=1.
  - When mem_ready=1: goes to FETCH and asserts instr_done. Otherwise holds.
- REX: aluop=2, alusrcB=0; alusrcA=2 when funct is 0x00 or 0x02, else 1. Goes to RWB.
- RWB: regwrite=1, regdest=1, memtoreg=0. Goes to FETCH.
- IEX: alusrcA=1, alusrcB=2, aluop=0. Goes to IWB.
- IWB: regwrite=1, regdest=0, memtoreg=0. Goes to FETCH.
- BEQ: alusrcA=1, alusrcB=0, aluop=1, pcsrc=1, pcen=zero. Goes to FETCH.
- JMP: pcsrc=2, pcen=1. Goes to FETCH.
- JR: pcsrc=3, pcen=1. Goes to FETCH.
- HALT: all outputs 0. Left only by reset.
- instr_done is asserted in the final cycle of each instruction: MEMWB, MEMWR (when mem_ready=1), RWB, IWB, BEQ, JMP, JR.
- retired increments by 1 on every cycle with instr_done=1. It wraps modulo 2^CNT_W.

## Timing
- Reset:
  - Asynchronous assertion: state=FETCH, retired=0, illegal=0.
  - While reset is high, all strobes and outputs are forced to 0.
  - The first fetch begins on the first clk edge after release.
- Outputs are decoded from the state register. Exceptions: pcen in BEQ depends on zero, and irwrite/pcen in FETCH depend on mem_ready.
- Cycle counts with mem_ready tied to 1:
  - lw 5.
  - sw, R-type, addi/addiu 4.
  - beq, j, jr 3.
  - Illegal opcode 2.
- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle and holds every output steady.
- mem_ready is ignored in all other states.
- Reset asserted mid-instruction aborts it: no writeback, no count. Execution restarts at FETCH.

## Test plan
- Reset mid-MEMRD → all outputs 0 at once; after release, state=FETCH with memread=1 and iord=0; retired=0.
- lw (opcode 0x23), mem_ready=1 → 5 cycles; regwrite=1 and memtoreg=1 only in cycle 5; instr_done pulses once; retired goes 0→1.
- sw (opcode 0x2B) with mem_ready low for 3 cycles in MEMWR → memwrite held for 4 cycles; no regwrite; 7 cycles total.
- beq (opcode 0x04) with zero=1, then with zero=0 → pcen=1 with pcsrc=1 in cycle 3, then pcen=0 in cycle 3; both take 3 cycles and increment retired.
- R-type: sll (funct 0x00) → alusrcA=2 in REX; add (funct 0x20) → alusrcA=1; jr (funct 0x08) → pcsrc=3, pcen=1, regwrite never asserted.
- Opcode 0x3F: with HALT_ON_ILLEGAL=0 → illegal=1, back in FETCH after 2 cycles, retired unchanged. With HALT_ON_ILLEGAL=1 → HALT with all outputs 0 until reset.
- Counter wrap: CNT_W=4, retire 16 j instructions → retired wraps to 0.

Source files
------------

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Moore control FSM for a shared-memory multicycle MIPS datapath. One memory
// port serves both instruction fetch and data access, and one ALU computes the
// PC increment, the branch target and the execute result. Each instruction
// steps through fetch, decode, execute, memory and writeback as needed. FETCH,
// MEMRD and MEMWR wait on a memory-ready handshake. Retired instructions are
// counted.
//
// Supported instructions: sll, srl, jr, other R-type, addi, addiu, lw, sw,
// beq and j.
//
// Parameters
//   CNT_W            width of the retired-instruction counter
//   HALT_ON_ILLEGAL  1: park in HALT on an unsupported opcode
//                    0: skip that instruction and fetch the next one
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   opcode      instruction register [31:26]
//   funct       instruction register [5:0]
//   zero        ALU zero flag
//   mem_ready   memory finishes the current read or write this cycle
//   iord        memory address select (0 = PC, 1 = ALUOut)
//   memread     memory read strobe
//   memwrite    memory write strobe
//   irwrite     instruction register load
//   regdest     destination register (1 = rd, 0 = rt)
//   memtoreg    writeback data (1 = MDR, 0 = ALUOut)
//   regwrite    register file write
//   alusrcA     ALU A (0 = PC, 1 = reg A, 2 = shamt)
//   alusrcB     ALU B (0 = reg B, 1 = 4, 2 = sext imm, 3 = sext imm << 2)
//   aluop       0 = add, 1 = sub, 2 = decode from funct
//   pcsrc       next PC (0 = ALU, 1 = ALUOut, 2 = jump target, 3 = reg A)
//   pcen        PC write enable
//   instr_done  pulse in the final cycle of each retired instruction
//   retired     retired-instruction count, wraps modulo 2^CNT_W
//   illegal     sticky flag, set when an unsupported opcode is decoded
// -----------------------------------------------------------------------------
module multicycle_controller #(
  parameter int CNT_W           = 32,
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             iord,
  output logic             memread,
  output logic             memwrite,
  output logic             irwrite,
  output logic             regdest,
  output logic             memtoreg,
  output logic             regwrite,
  output logic [1:0]       alusrcA,
  output logic [1:0]       alusrcB,
  output logic [1:0]       aluop,
  output logic [1:0]       pcsrc,
  output logic             pcen,
  output logic             instr_done,
  output logic [CNT_W-1:0] retired,
  output logic             illegal
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_JR    = 6'h08;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    REX    = 4'd6,
    RWB    = 4'd7,
    IEX    = 4'd8,
    IWB    = 4'd9,
    BEQ    = 4'd10,
    JMP    = 4'd11,
    JR     = 4'd12,
    HALT   = 4'd13
  } state_t;

  state_t           state_q, state_d;
  state_t           out_state_s;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             illegal_q, illegal_d;

  // Next-state, sticky illegal flag and retire counter
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    retired_d = retired_q + {{(CNT_W-1){1'b0}}, instr_done};
    case (state_q)
      FETCH: begin
        if (mem_ready) state_d = DECODE;
        else           state_d = FETCH;
      end
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW:      state_d = MEMADR;
          OP_RTYPE: begin
            if (funct == FN_JR) state_d = JR;
            else                state_d = REX;
          end
          OP_ADDI, OP_ADDIU: state_d = IEX;
          OP_BEQ:            state_d = BEQ;
          OP_J:              state_d = JMP;
          default: begin
            illegal_d = 1'b1;
            if (HALT_ON_ILLEGAL) state_d = HALT;
            else                 state_d = FETCH;
          end
        endcase
      end
      // The instruction register still holds the opcode, so lw/sw split here
      MEMADR: begin
        if (opcode == OP_LW) state_d = MEMRD;
        else                 state_d = MEMWR;
      end
      MEMRD: begin
        if (mem_ready) state_d = MEMWB;
        else           state_d = MEMRD;
      end
      MEMWR: begin
        if (mem_ready) state_d = FETCH;
        else           state_d = MEMWR;
      end
      REX:  state_d = RWB;
      IEX:  state_d = IWB;
      MEMWB, RWB, IWB, BEQ, JMP, JR: state_d = FETCH;
      HALT: state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // State, counter and flag registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH;
      retired_q <= {CNT_W{1'b0}};
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
    end
  end

  // While reset is high the decode sees HALT, whose outputs are all zero,
  // so every strobe is forced low without a separate gating path.
  assign out_state_s = reset ? HALT : state_q;

  // Output decode from the state register (plus mem_ready/zero exceptions)
  always_comb begin
    iord       = 1'b0;
    memread    = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regdest    = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    alusrcA    = 2'd0;
    alusrcB    = 2'd0;
    aluop      = 2'd0;
    pcsrc      = 2'd0;
    pcen       = 1'b0;
    instr_done = 1'b0;
    case (out_state_s)
      FETCH: begin
        memread = 1'b1;
        alusrcB = 2'd1;
        irwrite = mem_ready;
        pcen    = mem_ready;
      end
      DECODE: begin
        alusrcB = 2'd3;
      end
      MEMADR, IEX: begin
        alusrcA = 2'd1;
        alusrcB = 2'd2;
      end
      MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
      end
      MEMWB: begin
        regwrite   = 1'b1;
        memtoreg   = 1'b1;
        instr_done = 1'b1;
      end
      MEMWR: begin
        memwrite   = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
      end
      REX: begin
        aluop = 2'd2;
        // Shifts take their A operand from the shamt field
        if ((funct == FN_SLL) || (funct == FN_SRL)) alusrcA = 2'd2;
        else                                        alusrcA = 2'd1;
      end
      RWB: begin
        regwrite   = 1'b1;
        regdest    = 1'b1;
        instr_done = 1'b1;
      end
      IWB: begin
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      BEQ: begin
        alusrcA    = 2'd1;
        aluop      = 2'd1;
        pcsrc      = 2'd1;
        pcen       = zero;
        instr_done = 1'b1;
      end
      JMP: begin
        pcsrc      = 2'd2;
        pcen       = 1'b1;
        instr_done = 1'b1;
      end
      JR: begin
        pcsrc      = 2'd3;
        pcen       = 1'b1;
        instr_done = 1'b1;
      end
      HALT: begin
        pcen = 1'b0;
      end
      default: begin
        pcen = 1'b0;
      end
    endcase
  end

  assign retired = retired_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

  logic       clk;
  logic       reset0, reset1;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;

  logic       iord0, memread0, memwrite0, irwrite0, regdest0, memtoreg0, regwrite0;
  logic [1:0] alusrcA0, alusrcB0, aluop0, pcsrc0;
  logic       pcen0, instr_done0, illegal0;
  logic [3:0] retired0;

  logic       iord1, memread1, memwrite1, irwrite1, regdest1, memtoreg1, regwrite1;
  logic [1:0] alusrcA1, alusrcB1, aluop1, pcsrc1;
  logic       pcen1, instr_done1, illegal1;
  logic [31:0] retired1;

  logic [16:0] outs0, outs1;

  int n_checks = 0;
  int n_errors = 0;

  logic [16:0] F1, F0, DEC, MADR, MRD, MWB, MWR0, MWR1, REXS, REXA, RWB, IWB;
  logic [16:0] BEQ1, BEQ0, JMP, JR, ZERO;

  // Small counter, skip on illegal
  multicycle_controller #(.CNT_W(4), .HALT_ON_ILLEGAL(1'b0)) dut0 (
    .clk(clk), .reset(reset0), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .iord(iord0), .memread(memread0), .memwrite(memwrite0),
    .irwrite(irwrite0), .regdest(regdest0), .memtoreg(memtoreg0), .regwrite(regwrite0),
    .alusrcA(alusrcA0), .alusrcB(alusrcB0), .aluop(aluop0), .pcsrc(pcsrc0),
    .pcen(pcen0), .instr_done(instr_done0), .retired(retired0), .illegal(illegal0)
  );

  // Default counter, halt on illegal
  multicycle_controller #(.CNT_W(32), .HALT_ON_ILLEGAL(1'b1)) dut1 (
    .clk(clk), .reset(reset1), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .iord(iord1), .memread(memread1), .memwrite(memwrite1),
    .irwrite(irwrite1), .regdest(regdest1), .memtoreg(memtoreg1), .regwrite(regwrite1),
    .alusrcA(alusrcA1), .alusrcB(alusrcB1), .aluop(aluop1), .pcsrc(pcsrc1),
    .pcen(pcen1), .instr_done(instr_done1), .retired(retired1), .illegal(illegal1)
  );

  assign outs0 = {iord0, memread0, memwrite0, irwrite0, regdest0, memtoreg0, regwrite0,
                  alusrcA0, alusrcB0, aluop0, pcsrc0, pcen0, instr_done0};
  assign outs1 = {iord1, memread1, memwrite1, irwrite1, regdest1, memtoreg1, regwrite1,
                  alusrcA1, alusrcB1, aluop1, pcsrc1, pcen1, instr_done1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic logic [16:0] ctl(input logic iord, input logic mr, input logic mw,
                                      input logic irw, input logic rd, input logic mtr,
                                      input logic rw, input logic [1:0] asa,
                                      input logic [1:0] asb, input logic [1:0] aop,
                                      input logic [1:0] ps, input logic pe, input logic dn);
    return {iord, mr, mw, irw, rd, mtr, rw, asa, asb, aop, ps, pe, dn};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Check one cycle of a DUT's outputs, then advance to the next falling edge
  task automatic step(input string tag, input int sel, input logic [16:0] exp);
    #1;
    if (sel == 0) check(tag, {15'd0, outs0}, {15'd0, exp});
    else          check(tag, {15'd0, outs1}, {15'd0, exp});
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    F1   = ctl(1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,2'd0,2'd1,2'd0,2'd0,1'b1,1'b0);
    F0   = ctl(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd1,2'd0,2'd0,1'b0,1'b0);
    DEC  = ctl(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd3,2'd0,2'd0,1'b0,1'b0);
    MADR = ctl(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd1,2'd2,2'd0,2'd0,1'b0,1'b0);
    MRD  = ctl(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,2'd0,2'd0,1'b0,1'b0);
    MWB  = ctl(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,2'd0,2'd0,2'd0,2'd0,1'b0,1'b1);
    MWR0 = ctl(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,2'd0,2'd0,1'b0,1'b0);
    MWR1 = ctl(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,2'd0,2'd0,1'b0,1'b1);
    REXS = ctl(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd2,2'd0,2'd2,2'd0,1'b0,1'b0);
    REXA = ctl(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd1,2'd0,2'd2,2'd0,1'b0,1'b0);
    RWB  = ctl(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,2'd0,2'd0,2'd0,2'd0,1'b0,1'b1);
    IWB  = ctl(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,2'd0,2'd0,2'd0,1'b0,1'b1);
    BEQ1 = ctl(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd1,2'd0,2'd1,2'd1,1'b1,1'b1);
    BEQ0 = ctl(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd1,2'd0,2'd1,2'd1,1'b0,1'b1);
    JMP  = ctl(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,2'd0,2'd2,1'b1,1'b1);
    JR   = ctl(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,2'd0,2'd3,1'b1,1'b1);
    ZERO = 17'd0;

    reset0 = 1'b1; reset1 = 1'b1;
    opcode = 6'h23; funct = 6'h00; zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_outs0", {15'd0, outs0}, 32'd0);
    check("rst_outs1", {15'd0, outs1}, 32'd0);
    check("rst_retired", {28'd0, retired0}, 32'd0);
    check("rst_illegal", {31'd0, illegal0}, 32'd0);

    // lw: 5 cycles
    @(negedge clk);
    reset0 = 1'b0;
    step("lw_fetch", 0, F1);
    step("lw_decode", 0, DEC);
    step("lw_memadr", 0, MADR);
    step("lw_memrd", 0, MRD);
    step("lw_memwb", 0, MWB);
    check("lw_retired", {28'd0, retired0}, 32'd1);

    // sw with 3 stall cycles in MEMWR: 7 cycles
    opcode = 6'h2B;
    step("sw_fetch", 0, F1);
    step("sw_decode", 0, DEC);
    step("sw_memadr", 0, MADR);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("sw_memwr_wait", 0, MWR0);
    mem_ready = 1'b1;
    step("sw_memwr_done", 0, MWR1);
    check("sw_retired", {28'd0, retired0}, 32'd2);

    // beq taken and not taken
    opcode = 6'h04; zero = 1'b1;
    step("beq1_fetch", 0, F1);
    step("beq1_decode", 0, DEC);
    step("beq1_exec", 0, BEQ1);
    check("beq1_retired", {28'd0, retired0}, 32'd3);
    zero = 1'b0;
    step("beq0_fetch", 0, F1);
    step("beq0_decode", 0, DEC);
    step("beq0_exec", 0, BEQ0);
    check("beq0_retired", {28'd0, retired0}, 32'd4);

    // R-type: sll, add, jr
    opcode = 6'h00; funct = 6'h00;
    step("sll_fetch", 0, F1);
    step("sll_decode", 0, DEC);
    step("sll_rex", 0, REXS);
    step("sll_rwb", 0, RWB);
    funct = 6'h20;
    step("add_fetch", 0, F1);
    step("add_decode", 0, DEC);
    step("add_rex", 0, REXA);
    step("add_rwb", 0, RWB);
    funct = 6'h08;
    step("jr_fetch", 0, F1);
    step("jr_decode", 0, DEC);
    step("jr_exec", 0, JR);
    check("rtype_retired", {28'd0, retired0}, 32'd7);

    // addi
    opcode = 6'h08;
    step("addi_fetch", 0, F1);
    step("addi_decode", 0, DEC);
    step("addi_iex", 0, MADR);
    step("addi_iwb", 0, IWB);

    // j with 2 fetch stall cycles
    opcode = 6'h02; mem_ready = 1'b0;
    step("j_fetch_wait", 0, F0);
    step("j_fetch_wait", 0, F0);
    mem_ready = 1'b1;
    step("j_fetch", 0, F1);
    step("j_decode", 0, DEC);
    step("j_exec", 0, JMP);
    check("j_retired", {28'd0, retired0}, 32'd9);

    // illegal opcode, skip mode
    opcode = 6'h3F;
    step("ill_fetch", 0, F1);
    step("ill_decode", 0, DEC);
    #1;
    check("ill_back_fetch", {15'd0, outs0}, {15'd0, F1});
    check("ill_flag", {31'd0, illegal0}, 32'd1);
    check("ill_retired", {28'd0, retired0}, 32'd9);

    // reset in the middle of MEMRD
    opcode = 6'h23;
    step("rlw_fetch", 0, F1);
    step("rlw_decode", 0, DEC);
    step("rlw_memadr", 0, MADR);
    #1;
    check("rlw_memrd", {15'd0, outs0}, {15'd0, MRD});
    reset0 = 1'b1;
    #1;
    check("rlw_rst_outs", {15'd0, outs0}, 32'd0);
    check("rlw_rst_retired", {28'd0, retired0}, 32'd0);
    check("rlw_rst_illegal", {31'd0, illegal0}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset0 = 1'b0;
    opcode = 6'h02;

    // 16 jumps wrap the 4-bit counter; first fetch also checks post-reset state
    for (int i = 0; i < 16; i++) begin
      step("wrap_fetch", 0, F1);
      step("wrap_decode", 0, DEC);
      step("wrap_jmp", 0, JMP);
      if (i == 0) check("wrap_first", {28'd0, retired0}, 32'd1);
      else if (i == 14) check("wrap_15", {28'd0, retired0}, 32'd15);
    end
    check("wrap_zero", {28'd0, retired0}, 32'd0);

    // illegal opcode, halt mode
    opcode = 6'h3F;
    reset1 = 1'b0;
    step("halt_fetch", 1, F1);
    step("halt_decode", 1, DEC);
    step("halt_park", 1, ZERO);
    mem_ready = 1'b0;
    step("halt_park", 1, ZERO);
    mem_ready = 1'b1;
    opcode = 6'h02;
    step("halt_park", 1, ZERO);
    #1;
    check("halt_flag", {31'd0, illegal1}, 32'd1);
    check("halt_retired", retired1, 32'd0);
    reset1 = 1'b1;
    #1;
    check("halt_rst_flag", {31'd0, illegal1}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset1 = 1'b0;
    step("halt_restart", 1, F1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
